ext_periph_obi_demux: RTL and testbench

- Parametrised OBI 1-to-N demultiplexer for the external peripheral region.
- Successor to the fixed six-entry external-peripheral address map: the rule count and outstanding depth are generic, and it adds an internal error responder for unmapped addresses, outstanding-transaction tracking with port locking, and error/statistics outputs.
- Sits between the MCU external peripheral master port and the testharness peripherals (memcopy, AMS, IFFIFO, ...).

---
 rtl/ext_periph_demux_pkg.sv | 33 +++
 rtl/ext_periph_addr_decoder.sv | 28 ++
 rtl/ext_periph_obi_demux.sv | 162 ++++++++++++++++
 tb/tb_ext_periph_obi_demux.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_periph_demux_pkg.sv
// Shared types and constants for the external-peripheral OBI demux.
// Address rules are {idx, start, end) with an exclusive end address.
package ext_periph_demux_pkg;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } addr_map_rule_t;

   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADACCE5;
   localparam int unsigned ERR_CNT_W = 16;

   localparam logic [31:0] EXT_PERIPHERAL_START = 32'h2000_0000;
   localparam int unsigned DEFAULT_NPORT = 6;

   // Six consecutive 4 KiB windows above the region base.
   localparam addr_map_rule_t [DEFAULT_NPORT-1:0] DEFAULT_RULES = '{
      '{idx: 32'd5, start_addr: EXT_PERIPHERAL_START + 32'h5000,
        end_addr: EXT_PERIPHERAL_START + 32'h6000},
      '{idx: 32'd4, start_addr: EXT_PERIPHERAL_START + 32'h4000,
        end_addr: EXT_PERIPHERAL_START + 32'h5000},
      '{idx: 32'd3, start_addr: EXT_PERIPHERAL_START + 32'h3000,
        end_addr: EXT_PERIPHERAL_START + 32'h4000},
      '{idx: 32'd2, start_addr: EXT_PERIPHERAL_START + 32'h2000,
        end_addr: EXT_PERIPHERAL_START + 32'h3000},
      '{idx: 32'd1, start_addr: EXT_PERIPHERAL_START + 32'h1000,
        end_addr: EXT_PERIPHERAL_START + 32'h2000},
      '{idx: 32'd0, start_addr: EXT_PERIPHERAL_START + 32'h0000,
        end_addr: EXT_PERIPHERAL_START + 32'h1000}
   };

endpackage

// File: rtl/ext_periph_addr_decoder.sv
// Combinational rule matcher: per-rule hit vector and the port index
// of the lowest-numbered matching rule.
module ext_periph_addr_decoder
   import ext_periph_demux_pkg::*;
#(
   parameter int unsigned NPORT = 6,
   parameter int unsigned SEL_W = 3,
   parameter addr_map_rule_t [NPORT-1:0] ADDR_RULES = '0
) (
   input  logic [31:0]      addr_i,
   output logic [NPORT-1:0] hit_o,
   output logic [SEL_W-1:0] sel_o
);

   always_comb begin
      hit_o = '0;
      sel_o = '0;
      for (int i = 0; i < NPORT; i++) begin
         hit_o[i] = (addr_i >= ADDR_RULES[i].start_addr) &&
                    (addr_i <  ADDR_RULES[i].end_addr);
      end
      // Walk downwards so the lowest matching rule is written last.
      for (int i = NPORT - 1; i >= 0; i--) begin
         if (hit_o[i]) sel_o = ADDR_RULES[i].idx[SEL_W-1:0];
      end
   end

endmodule

// File: rtl/ext_periph_obi_demux.sv
// OBI 1-to-N demux with port locking, outstanding tracking and an
// internal error responder for unmapped addresses.
module ext_periph_obi_demux
   import ext_periph_demux_pkg::*;
#(
   parameter int unsigned NPORT = 6,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter addr_map_rule_t [NPORT-1:0] ADDR_RULES = DEFAULT_RULES,
   parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT,
   parameter int unsigned PORT_SEL_WIDTH = NPORT > 1 ? $clog2(NPORT) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       mst_req_i,
   output logic                       mst_gnt_o,
   input  logic [31:0]                mst_addr_i,
   input  logic                       mst_we_i,
   input  logic [3:0]                 mst_be_i,
   input  logic [31:0]                mst_wdata_i,
   output logic                       mst_rvalid_o,
   output logic [31:0]                mst_rdata_o,
   output logic                       mst_err_o,
   output logic [NPORT-1:0]           slv_req_o,
   input  logic [NPORT-1:0]           slv_gnt_i,
   output logic [31:0]                slv_addr_o,
   output logic                       slv_we_o,
   output logic [3:0]                 slv_be_o,
   output logic [31:0]                slv_wdata_o,
   input  logic [NPORT-1:0]           slv_rvalid_i,
   input  logic [NPORT-1:0][31:0]     slv_rdata_i,
   output logic [ERR_CNT_W-1:0]       err_count_o,
   output logic [31:0]                err_addr_o,
   output logic                       protocol_err_o
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      lock_err_q, lock_err_d;
   logic [PORT_SEL_WIDTH-1:0] lock_idx_q, lock_idx_d;
   logic                      err_pend_q, err_pend_d;
   logic [ERR_CNT_W-1:0]      err_cnt_q, err_cnt_d;
   logic [31:0]               err_addr_q, err_addr_d;
   logic                      prot_q, prot_d;

   logic [NPORT-1:0]          dec_hit;
   logic [PORT_SEL_WIDTH-1:0] dec_sel;
   logic                      tgt_err, stall, accepted, retire;
   logic                      map_rvalid, prot_hit, sel_gnt;
   logic [31:0]               map_rdata;

   ext_periph_addr_decoder #(
      .NPORT      (NPORT),
      .SEL_W      (PORT_SEL_WIDTH),
      .ADDR_RULES (ADDR_RULES)
   ) u_dec (
      .addr_i (mst_addr_i),
      .hit_o  (dec_hit),
      .sel_o  (dec_sel)
   );

   assign tgt_err = ~|dec_hit;

   assign slv_addr_o  = mst_addr_i;
   assign slv_we_o    = mst_we_i;
   assign slv_be_o    = mst_be_i;
   assign slv_wdata_o = mst_wdata_i;

   // Any target change while busy waits, so responses stay in order.
   assign stall = (cnt_q == CNT_MAX) ||
                  ((cnt_q != '0) &&
                   ((tgt_err != lock_err_q) ||
                    (!tgt_err && (dec_sel != lock_idx_q))));

   always_comb begin
      slv_req_o = '0;
      mst_gnt_o = 1'b0;
      sel_gnt   = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
         if (dec_sel == PORT_SEL_WIDTH'(i)) sel_gnt = slv_gnt_i[i];
      end
      if (rst_ni && !stall) begin
         if (tgt_err) begin
            mst_gnt_o = mst_req_i;
         end else begin
            mst_gnt_o = sel_gnt;
            for (int i = 0; i < NPORT; i++) begin
               slv_req_o[i] = mst_req_i && (dec_sel == PORT_SEL_WIDTH'(i));
            end
         end
      end
   end

   assign accepted = mst_req_i & mst_gnt_o;

   always_comb begin
      map_rvalid = 1'b0;
      map_rdata  = '0;
      prot_hit   = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
         if (slv_rvalid_i[i]) begin
            if ((cnt_q != '0) && !lock_err_q &&
                (lock_idx_q == PORT_SEL_WIDTH'(i))) begin
               map_rvalid = 1'b1;
               map_rdata  = slv_rdata_i[i];
            end else begin
               prot_hit = 1'b1;
            end
         end
      end
   end

   assign mst_rvalid_o = lock_err_q ? (err_pend_q && (cnt_q != '0))
                                    : map_rvalid;
   assign mst_rdata_o  = lock_err_q ? ERR_RDATA : map_rdata;
   assign mst_err_o    = lock_err_q & mst_rvalid_o;
   assign retire       = mst_rvalid_o;

   always_comb begin
      cnt_d      = cnt_q + CNT_W'(accepted) - CNT_W'(retire);
      lock_err_d = lock_err_q;
      lock_idx_d = lock_idx_q;
      err_pend_d = accepted & tgt_err;
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
      prot_d     = prot_q | prot_hit;
      if (accepted) begin
         lock_err_d = tgt_err;
         lock_idx_d = tgt_err ? '0 : dec_sel;
      end
      if (accepted && tgt_err) begin
         err_addr_d = mst_addr_i;
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q      <= '0;
         lock_err_q <= 1'b0;
         lock_idx_q <= '0;
         err_pend_q <= 1'b0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
         prot_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         lock_err_q <= lock_err_d;
         lock_idx_q <= lock_idx_d;
         err_pend_q <= err_pend_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
         prot_q     <= prot_d;
      end
   end

   assign err_count_o    = err_cnt_q;
   assign err_addr_o     = err_addr_q;
   assign protocol_err_o = prot_q;

endmodule

// File: tb/tb_ext_periph_obi_demux.sv
// Directed bench: decode table plus hand-written lock, limit,
// error-responder and protocol-error sequences.
module tb_ext_periph_obi_demux;
   import ext_periph_demux_pkg::*;

   localparam int unsigned NP = 6;

   localparam addr_map_rule_t [NP-1:0] RULES = '{
      '{idx: 32'd5, start_addr: 32'h5000, end_addr: 32'h6000},
      '{idx: 32'd4, start_addr: 32'h4000, end_addr: 32'h5800},
      '{idx: 32'd3, start_addr: 32'h3000, end_addr: 32'h4000},
      '{idx: 32'd2, start_addr: 32'h2000, end_addr: 32'h3000},
      '{idx: 32'd1, start_addr: 32'h1000, end_addr: 32'h2000},
      '{idx: 32'd0, start_addr: 32'h0000, end_addr: 32'h1000}
   };

   logic              clk = 1'b0;
   logic              rst_n;
   logic              mst_req;
   logic              mst_gnt;
   logic [31:0]       mst_addr;
   logic              mst_we;
   logic [3:0]        mst_be;
   logic [31:0]       mst_wdata;
   logic              mst_rvalid;
   logic [31:0]       mst_rdata;
   logic              mst_err;
   logic [NP-1:0]     slv_req;
   logic [NP-1:0]     slv_gnt;
   logic [31:0]       slv_addr;
   logic              slv_we;
   logic [3:0]        slv_be;
   logic [31:0]       slv_wdata;
   logic [NP-1:0]     slv_rvalid;
   logic [NP-1:0][31:0] slv_rdata;
   logic [15:0]       err_count;
   logic [31:0]       err_addr;
   logic              prot_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ext_periph_obi_demux #(
      .NPORT           (NP),
      .MAX_OUTSTANDING (4),
      .ADDR_RULES      (RULES)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .mst_req_i      (mst_req),
      .mst_gnt_o      (mst_gnt),
      .mst_addr_i     (mst_addr),
      .mst_we_i       (mst_we),
      .mst_be_i       (mst_be),
      .mst_wdata_i    (mst_wdata),
      .mst_rvalid_o   (mst_rvalid),
      .mst_rdata_o    (mst_rdata),
      .mst_err_o      (mst_err),
      .slv_req_o      (slv_req),
      .slv_gnt_i      (slv_gnt),
      .slv_addr_o     (slv_addr),
      .slv_we_o       (slv_we),
      .slv_be_o       (slv_be),
      .slv_wdata_o    (slv_wdata),
      .slv_rvalid_i   (slv_rvalid),
      .slv_rdata_i    (slv_rdata),
      .err_count_o    (err_count),
      .err_addr_o     (err_addr),
      .protocol_err_o (prot_err)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic [31:0]   addr;
      logic [NP-1:0] gnt_in;
      logic [NP-1:0] exp_req;
      logic          exp_gnt;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{32'h0100, 6'h3F, 6'b000001, 1'b1};
      vecs[1] = '{32'h0100, 6'h3E, 6'b000001, 1'b0};
      vecs[2] = '{32'h0FFF, 6'h3F, 6'b000001, 1'b1};
      vecs[3] = '{32'h1000, 6'h3F, 6'b000010, 1'b1};
      vecs[4] = '{32'h5400, 6'h3F, 6'b010000, 1'b1};
      vecs[5] = '{32'h5FFF, 6'h3F, 6'b100000, 1'b1};
      vecs[6] = '{32'h6000, 6'h00, 6'b000000, 1'b1};
      vecs[7] = '{32'h8000, 6'h3F, 6'b000000, 1'b1};
      vecs[8] = '{32'h2ABC, 6'h04, 6'b000100, 1'b1};

      rst_n      = 1'b0;
      mst_req    = 1'b1;
      mst_addr   = 32'h0100;
      mst_we     = 1'b0;
      mst_be     = 4'hF;
      mst_wdata  = 32'h0;
      slv_gnt    = 6'h3F;
      slv_rvalid = '0;
      slv_rdata  = '0;

      // Reset held with a live request
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_gnt", {31'b0, mst_gnt}, 32'd0);
      chk("rst_req", {26'b0, slv_req}, 32'd0);
      chk("rst_rvalid", {31'b0, mst_rvalid}, 32'd0);
      chk("rst_errcnt", {16'b0, err_count}, 32'd0);
      chk("rst_prot", {31'b0, prot_err}, 32'd0);
      mst_req = 1'b0;
      rst_n   = 1'b1;
      cyc();

      // Decode table, idle state, request never spans a clock edge
      for (int i = 0; i < 9; i++) begin
         mst_addr = vecs[i].addr;
         slv_gnt  = vecs[i].gnt_in;
         mst_req  = 1'b1;
         #1;
         chk($sformatf("dec%0d_req", i), {26'b0, slv_req},
             {26'b0, vecs[i].exp_req});
         chk($sformatf("dec%0d_gnt", i), {31'b0, mst_gnt},
             {31'b0, vecs[i].exp_gnt});
         chk($sformatf("dec%0d_addr", i), slv_addr, vecs[i].addr);
         mst_req = 1'b0;
         cyc();
      end
      slv_gnt = 6'h3F;

      // Mapped read, response two cycles after accept
      mst_addr = 32'h0100;
      mst_req  = 1'b1;
      #1;
      chk("rd_gnt", {31'b0, mst_gnt}, 32'd1);
      cyc();
      mst_req = 1'b0;
      cyc();
      slv_rvalid[0] = 1'b1;
      slv_rdata[0]  = 32'h1234_5678;
      #1;
      chk("rd_rvalid", {31'b0, mst_rvalid}, 32'd1);
      chk("rd_rdata", mst_rdata, 32'h1234_5678);
      chk("rd_err", {31'b0, mst_err}, 32'd0);
      cyc();
      slv_rvalid = '0;

      // Unmapped write
      mst_addr  = 32'h8000;
      mst_we    = 1'b1;
      mst_wdata = 32'hA5A5_0001;
      mst_req   = 1'b1;
      #1;
      chk("um_gnt", {31'b0, mst_gnt}, 32'd1);
      chk("um_req", {26'b0, slv_req}, 32'd0);
      cyc();
      mst_req = 1'b0;
      mst_we  = 1'b0;
      #1;
      chk("um_rvalid", {31'b0, mst_rvalid}, 32'd1);
      chk("um_rdata", mst_rdata, 32'hBADACCE5);
      chk("um_err", {31'b0, mst_err}, 32'd1);
      chk("um_errcnt", {16'b0, err_count}, 32'd1);
      chk("um_erraddr", err_addr, 32'h8000);
      cyc();
      chk("um_rvalid_off", {31'b0, mst_rvalid}, 32'd0);

      // Port lock: port 2 waits for port 1 response
      mst_addr = 32'h1000;
      mst_req  = 1'b1;
      #1;
      chk("lk_gnt1", {31'b0, mst_gnt}, 32'd1);
      cyc();
      mst_addr = 32'h2000;
      #1;
      chk("lk_stall_gnt", {31'b0, mst_gnt}, 32'd0);
      chk("lk_stall_req", {26'b0, slv_req}, 32'd0);
      cyc();
      slv_rvalid[1] = 1'b1;
      slv_rdata[1]  = 32'hCAFE_0001;
      #1;
      chk("lk_rvalid1", {31'b0, mst_rvalid}, 32'd1);
      chk("lk_rdata1", mst_rdata, 32'hCAFE_0001);
      chk("lk_retire_gnt", {31'b0, mst_gnt}, 32'd0);
      cyc();
      slv_rvalid = '0;
      #1;
      chk("lk_gnt2", {31'b0, mst_gnt}, 32'd1);
      chk("lk_req2", {26'b0, slv_req}, 32'b000100);
      cyc();
      mst_req = 1'b0;
      slv_rvalid[2] = 1'b1;
      slv_rdata[2]  = 32'hCAFE_0002;
      #1;
      chk("lk_rdata2", mst_rdata, 32'hCAFE_0002);
      cyc();
      slv_rvalid = '0;

      // Outstanding limit of four
      mst_addr = 32'h0100;
      mst_req  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("ol_gnt%0d", k), {31'b0, mst_gnt}, 32'd1);
         cyc();
      end
      #1;
      chk("ol_full_gnt", {31'b0, mst_gnt}, 32'd0);
      chk("ol_full_req", {26'b0, slv_req}, 32'd0);
      cyc();
      slv_rvalid[0] = 1'b1;
      slv_rdata[0]  = 32'h0000_0011;
      #1;
      chk("ol_rvalid", {31'b0, mst_rvalid}, 32'd1);
      chk("ol_same_cyc_gnt", {31'b0, mst_gnt}, 32'd0);
      cyc();
      slv_rvalid = '0;
      #1;
      chk("ol_slot_gnt", {31'b0, mst_gnt}, 32'd1);
      cyc();
      mst_req = 1'b0;
      slv_rvalid[0] = 1'b1;
      repeat (4) cyc();
      slv_rvalid = '0;
      mst_addr = 32'h3000;
      mst_req  = 1'b1;
      #1;
      chk("ol_drained_gnt", {31'b0, mst_gnt}, 32'd1);
      chk("ol_drained_req", {26'b0, slv_req}, 32'b001000);
      mst_req = 1'b0;
      cyc();

      // Back-to-back unmapped accesses
      mst_addr = 32'h9000;
      mst_req  = 1'b1;
      #1;
      chk("bb_gnt1", {31'b0, mst_gnt}, 32'd1);
      cyc();
      mst_addr = 32'hA000;
      #1;
      chk("bb_rvalid1", {31'b0, mst_rvalid}, 32'd1);
      chk("bb_gnt2", {31'b0, mst_gnt}, 32'd1);
      cyc();
      mst_req = 1'b0;
      #1;
      chk("bb_rvalid2", {31'b0, mst_rvalid}, 32'd1);
      chk("bb_err2", {31'b0, mst_err}, 32'd1);
      chk("bb_errcnt", {16'b0, err_count}, 32'd3);
      chk("bb_erraddr", err_addr, 32'hA000);
      cyc();
      chk("bb_idle", {31'b0, mst_rvalid}, 32'd0);

      // Stray response while idle
      slv_rvalid[3] = 1'b1;
      slv_rdata[3]  = 32'hDEAD_0003;
      #1;
      chk("pe_rvalid", {31'b0, mst_rvalid}, 32'd0);
      cyc();
      slv_rvalid = '0;
      #1;
      chk("pe_set", {31'b0, prot_err}, 32'd1);
      cyc();
      cyc();
      chk("pe_sticky", {31'b0, prot_err}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no_finish expected finish");
      $fatal(1);
   end

endmodule
